// File: rtl/bcd_key_entry_if.sv
// Operand handshake between the key-entry block and its consumer.
// The master presents din_out/din_valid; the slave answers with din_ready.
interface bcd_key_entry_if;
    logic [15:0] din_out;
    logic        din_valid;
    logic        din_ready;

    modport master (
        output din_out,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din_out,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/bcd_key_entry.sv
// Debounced decimal keypad entry: accumulates typed digits into a saturating 16-bit operand,
// hands it off with valid/ready and echoes the last four digits as BCD.
module bcd_key_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [3:0]         key_digit,
    input  logic               key_press,
    input  logic               key_enter,
    bcd_key_entry_if.master    din,
    output logic [2:0]         digit_count,
    output logic               overflow,
    output logic [15:0]        echo_bcd
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {StEntry, StHold} state_e;

    // Button chains indexed [0]=press, [1]=enter.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      level_q, level_prev_q;
    logic [1:0]      pulse_q;
    logic [CntW-1:0] cnt_q [2];
    logic [3:0]      dsync1_q, dsync2_q;
    logic            press_p, enter_p;

    state_e      state_q, state_d;
    logic [15:0] dout_q, dout_d;
    logic        valid_q, valid_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [15:0] echo_q, echo_d;
    logic [16:0] acc_next;

    assign btn_raw = {key_enter, key_press};
    assign press_p = pulse_q[0];
    assign enter_p = pulse_q[1];

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            pulse_q      <= '0;
            dsync1_q     <= '0;
            dsync2_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
            dsync1_q     <= key_digit;
            dsync2_q     <= dsync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        level_q[i] <= sync2_q[i];
                        cnt_q[i]   <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Only reached with at most four digits and no overflow, so 17 bits cannot wrap.
    assign acc_next = {1'b0, dout_q} * 17'd10 + {13'd0, dsync2_q};

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        echo_d  = echo_q;
        unique case (state_q)
            StEntry: begin
                if (enter_p) begin
                    if (count_q != 3'd0) begin
                        state_d = StHold;
                        valid_d = 1'b1;
                    end
                end else if (press_p && (dsync2_q <= 4'd9)) begin
                    echo_d = {echo_q[11:0], dsync2_q};
                    if (count_q < 3'd5) begin
                        count_d = count_q + 3'd1;
                        if (!ovf_q) begin
                            if (acc_next[16]) begin
                                dout_d = 16'hFFFF;
                                ovf_d  = 1'b1;
                            end else begin
                                dout_d = acc_next[15:0];
                            end
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (din.din_ready) begin
                    state_d = StEntry;
                    valid_d = 1'b0;
                    dout_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StEntry;
            dout_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            echo_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            echo_q  <= echo_d;
        end
    end

    assign din.din_out   = dout_q;
    assign din.din_valid = valid_q;
    assign digit_count   = count_q;
    assign overflow      = ovf_q;
    assign echo_bcd      = echo_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed bench for bcd_key_entry with DEBOUNCE_CYCLES=4 (press-to-update latency 8 edges).
module tb_bcd_key_entry;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  key_digit;
    logic        key_press;
    logic        key_enter;
    logic [2:0]  digit_count;
    logic        overflow;
    logic [15:0] echo_bcd;

    int n_cmp = 0;
    int n_err = 0;

    bcd_key_entry_if dif ();

    bcd_key_entry #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .key_digit  (key_digit),
        .key_press  (key_press),
        .key_enter  (key_enter),
        .din        (dif),
        .digit_count(digit_count),
        .overflow   (overflow),
        .echo_bcd   (echo_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_press = 1'b1;
        repeat (12) @(negedge clk);
        key_press = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic enter();
        key_enter = 1'b1;
        repeat (12) @(negedge clk);
        key_enter = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic accept();
        dif.din_ready = 1'b1;
        @(negedge clk);
        dif.din_ready = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        key_digit = 4'd0;
        key_press = 1'b0;
        key_enter = 1'b0;
        dif.din_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", dif.din_out, 0);
        check("rst_valid", dif.din_valid, 0);
        check("rst_count", digit_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_echo", echo_bcd, 0);
        clear = 1'b0;

        // Normal entry
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        enter();
        check("norm_dout", dif.din_out, 12345);
        check("norm_valid", dif.din_valid, 1);
        check("norm_count", digit_count, 5);
        check("norm_echo", echo_bcd, 32'h2345);
        check("norm_ovf", overflow, 0);
        accept();
        check("acc_valid", dif.din_valid, 0);
        check("acc_dout", dif.din_out, 0);
        check("acc_count", digit_count, 0);
        check("acc_echo", echo_bcd, 32'h2345);

        // Saturation: 65536 clamps to 65535
        press(4'd6); press(4'd5); press(4'd5); press(4'd3); press(4'd6);
        check("sat_ovf", overflow, 1);
        check("sat_dout", dif.din_out, 65535);
        check("sat_count", digit_count, 5);
        press(4'd9);
        check("sat6_echo", echo_bcd, 32'h5369);
        check("sat6_dout", dif.din_out, 65535);
        check("sat6_count", digit_count, 5);
        check("sat6_ovf", overflow, 1);
        enter();
        check("sat_hold_dout", dif.din_out, 65535);
        check("sat_hold_valid", dif.din_valid, 1);
        accept();
        check("sat_acc_ovf", overflow, 0);

        // Debounce: short pulse, bounce, then stable press of 8
        key_digit = 4'd8;
        key_press = 1'b1;
        repeat (3) @(negedge clk);
        key_press = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_count", digit_count, 0);
        for (int i = 0; i < 20; i++) begin
            key_press = ~key_press;
            @(negedge clk);
        end
        key_press = 1'b1;
        repeat (7) @(negedge clk);
        check("deb_early_count", digit_count, 0);
        @(negedge clk);
        check("deb_count", digit_count, 1);
        check("deb_dout", dif.din_out, 8);
        check("deb_echo", echo_bcd, 32'h3698);
        key_press = 1'b0;
        repeat (12) @(negedge clk);
        check("deb_once", digit_count, 1);

        // Illegal digit then drain, then enter with nothing typed
        press(4'hA);
        check("ill_count", digit_count, 1);
        check("ill_dout", dif.din_out, 8);
        check("ill_echo", echo_bcd, 32'h3698);
        enter();
        accept();
        enter();
        check("empty_valid", dif.din_valid, 0);

        // HOLD ignores digits
        press(4'd7);
        enter();
        check("hold_valid", dif.din_valid, 1);
        press(4'd9);
        check("hold_dout", dif.din_out, 7);
        check("hold_echo", echo_bcd, 32'h6987);
        check("hold_count", digit_count, 1);
        accept();

        // Simultaneous enter and digit: enter wins
        press(4'd2);
        key_digit = 4'd5;
        key_press = 1'b1;
        key_enter = 1'b1;
        repeat (12) @(negedge clk);
        key_press = 1'b0;
        key_enter = 1'b0;
        repeat (12) @(negedge clk);
        check("sim_valid", dif.din_valid, 1);
        check("sim_dout", dif.din_out, 2);
        check("sim_count", digit_count, 1);
        check("sim_echo", echo_bcd, 32'h9872);
        accept();

        // Clear mid-entry
        press(4'd1); press(4'd2); press(4'd3);
        check("mid_count", digit_count, 3);
        clear = 1'b1;
        @(negedge clk);
        check("mid_rst_count", digit_count, 0);
        check("mid_rst_dout", dif.din_out, 0);
        check("mid_rst_echo", echo_bcd, 0);
        clear = 1'b0;

        // Clear during HOLD
        press(4'd4);
        enter();
        check("hold2_valid", dif.din_valid, 1);
        clear = 1'b1;
        @(negedge clk);
        check("hold_rst_valid", dif.din_valid, 0);
        check("hold_rst_dout", dif.din_out, 0);
        check("hold_rst_echo", echo_bcd, 0);
        check("hold_rst_count", digit_count, 0);
        clear = 1'b0;

        // Button held across clear: one press 8 edges after release of clear
        key_digit = 4'd6;
        key_press = 1'b1;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (7) @(negedge clk);
        check("held_early_count", digit_count, 0);
        @(negedge clk);
        check("held_count", digit_count, 1);
        check("held_dout", dif.din_out, 6);
        key_press = 1'b0;
        repeat (12) @(negedge clk);
        check("held_once", digit_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_key_entry.md
# bcd_key_entry

Input-side counterpart to the decimal display path. It debounces the digit-entry and enter push-buttons and accumulates typed decimal digits into a 16-bit binary operand. It then presents that operand to the FSM/Datapath with a valid/ready handshake. It also echoes the last four typed digits as BCD so the display driver can show the entry in progress.

## Interface
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles (5 ms at 50 MHz) required before a button level is accepted. Minimum 2.
- clk  in  1  system clock; every register updates on its rising edge.
- clear  in  1  synchronous, active-high reset.
- key_digit  in  4  raw digit switches, binary 0–9; must be stable from before the press until after the release.
- key_press  in  1  raw, asynchronous digit-commit button.
- key_enter  in  1  raw, asynchronous operand-commit button.
- din_ready  in  1  the consumer (FSM) accepts the operand.
- din_out  out  16  assembled binary operand.
- din_valid  out  1  din_out is complete and held for the consumer.
- digit_count  out  3  digits accepted so far, 0–5.
- overflow  out  1  sticky; the entry exceeded 65535 and din_out is saturated.
- echo_bcd  out  16  last four accepted digits, newest in [3:0].

## Operation
- **Conditioning.** Each button (key_press, key_enter) has its own conditioning chain:
  - 2-flop synchronizer;
  - debouncer: a counter increments while the synchronized value differs from the debounced level, and resets to 0 when they match. On reaching DEBOUNCE_CYCLES−1 while still differing, the debounced level takes the new value;
  - registered rising-edge detector producing a 1-cycle pulse (press_p or enter_p).
- key_digit goes through its own 2-flop synchronizer and is sampled on press_p.
- **FSM states:** ENTRY (reset state) and HOLD.
- **ENTRY, press_p, digit d ≤ 9:**
  - echo_bcd ← {echo_bcd[11:0], d};
  - if overflow=0 and digit_count<5: compute acc×10+d in 17 bits. If the result is >65535, din_out←65535 and overflow←1; otherwise din_out←the result.
  - digit_count increments and saturates at 5. At 5, further digits set overflow and leave din_out unchanged.
- **ENTRY, press_p, digit d > 9:** ignored. No register changes.
- **ENTRY, enter_p:**
  - digit_count≠0: go to HOLD and set din_valid←1.
  - digit_count=0: ignored.
- **ENTRY, enter_p and press_p in the same cycle:** enter wins and the digit is discarded.
- **HOLD:** press_p and enter_p are ignored. din_out, overflow and echo_bcd are frozen.
- **HOLD, din_valid & din_ready at an edge:**
  - din_valid←0, din_out←0, digit_count←0, overflow←0;
  - echo_bcd is kept for display;
  - return to ENTRY.
- din_ready is ignored whenever din_valid=0.

## Timing
- **Reset values** (clear high at an edge; all values apply on that same edge and override every other event):
  - outputs: din_out=0, din_valid=0, digit_count=0, overflow=0, echo_bcd=0;
  - internals: state=ENTRY, synchronizers 0, debounce counters 0, debounced levels 0, edge pulses 0.
- A button held through clear deassertion produces exactly one press, DEBOUNCE_CYCLES+4 edges after clear deasserts.
- **Press latency:** when a raw button rises and stays stable, edges 1–2 are the synchronizer. The debounced level rises at edge DEBOUNCE_CYCLES+2, the pulse at edge DEBOUNCE_CYCLES+3, and din_out/digit_count/echo_bcd update at edge DEBOUNCE_CYCLES+4.
- **Glitches:** a raw pulse shorter than DEBOUNCE_CYCLES cycles after synchronization produces no pulse. Release bounce produces no pulse because only rising edges are detected.
- **Enter latency:** din_valid rises at edge DEBOUNCE_CYCLES+4 after key_enter rises.
- **Handshake:**
  - din_valid stays high and din_out stays stable until the edge where din_ready=1;
  - din_valid falls on that edge (one-cycle acceptance when ready is already high);
  - a new digit can be accepted on the next pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Normal entry.** Digits 1,2,3,4,5 then enter, din_ready low → din_out=16'd12345, din_valid=1, digit_count=5, echo_bcd=16'h2345. Raise din_ready → din_valid=0 one edge later, din_out=0, digit_count=0.
- **Saturation.** Digits 6,5,5,3,6 → after the fifth digit, overflow=1 and din_out=65535. A sixth digit changes only echo_bcd. After enter, din_out=65535 and din_valid=1.
- **Debounce.** key_press pulses of 3 cycles, then bouncy 1-cycle toggles for 20 cycles, then a stable high → exactly one digit accepted at the expected latency of 8 edges after the stable rise.
- **Illegal inputs.** Enter with zero digits → din_valid stays 0. Digit 4'hA → digit_count, din_out and echo_bcd unchanged.
- **HOLD and simultaneous events.**
  - Digits 7 then enter, then digit 9 pressed while in HOLD → din_out stays 7.
  - Back in ENTRY, enter_p and press_p forced in the same cycle → HOLD is entered and the digit is discarded.
- **Reset mid-operation.** Assert clear mid-entry with digit_count=3, and separately during HOLD with din_ready low → all outputs read their reset values at the next edge. A button held across clear yields one press DEBOUNCE_CYCLES+4 edges after clear deasserts.
